// File: rtl/ram_writer_pkg.sv
// Shared types and helpers for the stream-to-RAM row writer.
package ram_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest lane count the one-hot helper can express; callers size-cast the result.
    localparam int unsigned MAX_LANES = 64;

    function automatic logic [MAX_LANES-1:0] lane_onehot(input int unsigned idx);
        logic [MAX_LANES-1:0] vec;
        vec = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            vec[i] = (idx == i);
        end
        return vec;
    endfunction

endpackage

// File: rtl/ram_writer_out_stage.sv
// One register stage for the RAM write port. The enable clears every cycle,
// while address and data only reload on a write so they hold between writes.
module ram_writer_out_stage
    import ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 6,
    parameter int NUM_WORDS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_WORDS-1:0]  en_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [NUM_WORDS-1:0]  en_o,
    output logic [AW-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [NUM_WORDS-1:0]  en_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q <= en_i;
            if (|en_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign en_o   = en_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/ram_multi_word_writer.sv
// Packs a valid/ready word stream into multi-word RAM rows, one lane per transfer.
// Define RAM_WRITER_OUT_REG_EN to add a second output register stage (2-cycle write latency).
module ram_multi_word_writer
    import ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int NUM_WORDS  = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [AW-1:0]         base_addr_i,
    input  logic [AW:0]           num_rows_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [AW-1:0]         wr_addr_o,
    output logic [NUM_WORDS-1:0]  wr_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int LW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // DONE lingers until the last write has left the output pipeline plus one cycle.
`ifdef RAM_WRITER_OUT_REG_EN
    localparam logic [1:0] DONE_WAIT = 2'd2;
`else
    localparam logic [1:0] DONE_WAIT = 2'd1;
`endif

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW:0]     rows_q, rows_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [AW:0]     row_q, row_d;
    logic [1:0]      wait_q, wait_d;

    logic                  xfer;
    logic                  last_lane;
    logic                  last_row;
    logic [NUM_WORDS-1:0]  stage_en;
    logic [AW-1:0]         stage_addr;
    logic [DATA_WIDTH-1:0] stage_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            lane_q  <= '0;
            row_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            lane_q  <= lane_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
        end
    end

    assign xfer      = s_valid_i && (state_q == ST_LOAD);
    assign last_lane = (lane_q == LW'(NUM_WORDS - 1));
    assign last_row  = (row_q == (rows_q - (AW+1)'(1)));

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rows_d     = rows_q;
        lane_d     = lane_q;
        row_d      = row_q;
        wait_d     = wait_q;
        stage_en   = '0;
        stage_addr = base_q + row_q[AW-1:0];
        stage_data = s_data_i;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    rows_d  = num_rows_i;
                    lane_d  = '0;
                    row_d   = '0;
                    wait_d  = '0;
                    state_d = (num_rows_i == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    stage_en = NUM_WORDS'(lane_onehot(32'(lane_q)));
                    if (last_lane) begin
                        lane_d = '0;
                        row_d  = row_q + (AW+1)'(1);
                        if (last_row) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (wait_q == DONE_WAIT) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ready_o = (state_q == ST_LOAD);
    assign done_o    = (state_q == ST_DONE) && (wait_q == DONE_WAIT);
    assign busy_o    = (state_q != ST_IDLE) && !done_o;

`ifdef RAM_WRITER_OUT_REG_EN
    logic [NUM_WORDS-1:0]  mid_en;
    logic [AW-1:0]         mid_addr;
    logic [DATA_WIDTH-1:0] mid_data;

    ram_writer_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .NUM_WORDS  (NUM_WORDS)
    ) u_stage0 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (stage_en),
        .addr_i (stage_addr),
        .data_i (stage_data),
        .en_o   (mid_en),
        .addr_o (mid_addr),
        .data_o (mid_data)
    );

    ram_writer_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .NUM_WORDS  (NUM_WORDS)
    ) u_stage1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (mid_en),
        .addr_i (mid_addr),
        .data_i (mid_data),
        .en_o   (wr_en_o),
        .addr_o (wr_addr_o),
        .data_o (wr_data_o)
    );
`else
    ram_writer_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .NUM_WORDS  (NUM_WORDS)
    ) u_stage0 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (stage_en),
        .addr_i (stage_addr),
        .data_i (stage_data),
        .en_o   (wr_en_o),
        .addr_o (wr_addr_o),
        .data_o (wr_data_o)
    );
`endif

endmodule

// File: doc/ram_multi_word_writer.md
# ram_multi_word_writer

Stream-to-RAM loader directly upstream of `block_ram_multi_word`. It accepts a valid/ready stream of `DATA_WIDTH`-bit words and packs each group of `NUM_WORDS` consecutive words into one RAM row. Packing works by driving the RAM's shared `wr_data`, `wr_addr` and one-hot per-word `wr_en`. A single `start` command loads `num_rows` rows beginning at `base_addr`, then pulses `done`.

## Interface
- `DATA_WIDTH`, 8, word width; equals the RAM's `DATA_WIDTH`.
- `DEPTH`, 64, RAM rows; address width `AW = $clog2(DEPTH)`.
- `NUM_WORDS`, 4, words per row; equals the RAM's `NUM_WORDS`; must be ≥ 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle load command; sampled only in IDLE.
- `base_addr`  in  AW  first row address, captured on `start`.
- `num_rows`  in  AW+1  rows to load (0..DEPTH), captured on `start`.
- `s_data`  in  DATA_WIDTH  stream word.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  writer accepts a word this cycle.
- `wr_data`  out  DATA_WIDTH  to the RAM's `wr_data`.
- `wr_addr`  out  AW  to the RAM's `wr_addr`.
- `wr_en`  out  NUM_WORDS  one-hot lane write enable, to the RAM's `wr_en`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- FSM states are IDLE, LOAD and DONE.
- **IDLE**
  - `start`=1 captures `base_addr` and `num_rows`, clears the lane and row counters, and moves to LOAD.
  - If `num_rows`=0, the FSM moves directly to DONE instead.
- **LOAD**
  - `s_ready`=1, driven combinationally from state only (not dependent on `s_valid`).
  - A transfer occurs when `s_valid`&&`s_ready`.
  - Each transfer writes `s_data` into lane `lane` of row `(base + row) mod DEPTH`. Lane 0 maps to bits `[DATA_WIDTH-1:0]`.
  - `lane` increments per transfer. At `NUM_WORDS-1` it wraps to 0 and `row` increments.
  - The transfer that carries lane `NUM_WORDS-1` of row `num_rows-1` ends the load. The FSM moves to DONE and `s_ready` drops the next cycle.
- **DONE**: `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- `start` outside IDLE is ignored.
- `s_valid` in IDLE or DONE is not accepted.
- Address arithmetic is AW-bit modulo. For example, `base`=62 with `DEPTH`=64 writes rows 62, 63, 0, 1, …
- The row counter is AW+1 bits wide, so `num_rows`=DEPTH is legal and fills every row exactly once.
- Cycles without a transfer drive `wr_en`=0. `wr_data`/`wr_addr` hold their last values.

## Timing
- Reset values: FSM=IDLE, `s_ready`=0, `busy`=0, `done`=0, `wr_en`=0, `wr_data`=0, `wr_addr`=0, counters=0.
- Reset mid-LOAD aborts immediately. Rows already written stay in the RAM; a partially written row is not rolled back.
- Write latency is 1 cycle. A transfer at edge N presents `wr_en`/`wr_addr`/`wr_data` as registers during cycle N+1, for one cycle only.
- `done` is asserted in the cycle after the final `wr_en` pulse. `busy` is deasserted in the same cycle `done` is asserted.
- Back-to-back transfers give one RAM write per cycle, i.e. full throughput.
- Minimum loop from `start` to the next accepted `start`: `num_rows*NUM_WORDS` + 3 cycles with continuous `s_valid`.

## Configuration
- `RAM_WRITER_OUT_REG_EN`
  - Defined: adds a second register stage on `wr_en`/`wr_addr`/`wr_data` for timing closure. Write latency becomes 2 cycles.
  - Defined: `done` is delayed by one extra cycle so it still follows the final `wr_en` pulse by one cycle. `busy` stays high through that extra cycle.
  - Undefined: single-stage behaviour exactly as in Timing.
- Reset values are identical in both builds.

## Structure
- Shared package `ram_writer_pkg`: FSM state enum (`ST_IDLE`, `ST_LOAD`, `ST_DONE`) and a `lane_onehot` function (index to one-hot, width `NUM_WORDS`).
- One sub-module, `ram_writer_out_stage`: the parameterised output register stage, instantiated once normally and twice under `RAM_WRITER_OUT_REG_EN`.
- The counters and FSM stay in the top-level module.

## Test plan
- Basic load: `DATA_WIDTH`=8, `NUM_WORDS`=4, `base`=5, `num_rows`=2, stream 0x10..0x17 → RAM row 5 = 0x13121110, row 6 = 0x17161514. `wr_en` sequence is 1,2,4,8,1,2,4,8. `done` pulses one cycle after the last write.
- Wrap-around: `base`=63, `num_rows`=2 → writes land in rows 63 and 0; `wr_addr` never reaches 64.
- Gaps: `s_valid` toggles 1,0,0,1… → `wr_en`=0 on idle cycles, no duplicate or skipped lanes, final contents identical to the gap-free run.
- Degenerate commands:
  - `num_rows`=0 → `done` pulses 1 cycle after DONE is entered, no `wr_en` pulses, `s_ready` never high.
  - `start` asserted during LOAD → ignored; captured parameters are unchanged.
- Reset mid-load: assert `rst` after 6 of 8 words → all outputs 0 the same cycle, FSM in IDLE. A new `start` with `base`=0, `num_rows`=1 loads correctly.
- Full depth with `RAM_WRITER_OUT_REG_EN` defined: `num_rows`=64 → every row is written once. Write latency is 2 cycles, and `done` follows the last `wr_en` by 1 cycle.
